// File: rtl/nx_node_egress_arbiter.sv
// Egress arbiter: per-source 2-entry FIFOs, burst-limited round-robin selection,
// and a registered valid/ready output stage driving the node's single message port.

package nx_node_pkg;
   typedef struct packed {
      logic [3:0]  cmd;
      logic [11:0] addr;
      logic [15:0] payload;
   } node_message_t;
endpackage

module nx_node_egress_arbiter
   import nx_node_pkg::*;
#(
   parameter int INPUTS    = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   output logic                              idle_o,
   input  node_message_t [INPUTS-1:0]        in_data_i,
   input  logic [INPUTS-1:0]                 in_valid_i,
   output logic [INPUTS-1:0]                 in_ready_o,
   output node_message_t                     msg_data_o,
   output logic                              msg_valid_o,
   input  logic                              msg_ready_i,
   output logic [$clog2(INPUTS)-1:0]         grant_o
);

   localparam int GW = $clog2(INPUTS);
   localparam int BW = $clog2(MAX_BURST + 1);

   node_message_t     fifo_mem [INPUTS][2];
   logic [1:0]        fifo_cnt [INPUTS];
   logic              fifo_wp  [INPUTS];
   logic              fifo_rp  [INPUTS];
   logic [INPUTS-1:0] fifo_ne;
   logic [INPUTS-1:0] push;
   logic [INPUTS-1:0] pop;

   logic [GW-1:0]     rr_ptr;
   logic [BW-1:0]     burst_cnt;
   logic [GW-1:0]     rr_nxt;
   logic [BW-1:0]     burst_nxt;
   logic              load;
   logic              grant_vld;
   logic [GW-1:0]     grant_idx;
   logic [GW-1:0]     scan_idx;
   logic              any_ne;

   assign load = !msg_valid_o || msg_ready_i;

   // Ready is a function of the registered count only, so msg_ready_i never reaches a source.
   always_comb begin
      fifo_ne    = '0;
      in_ready_o = '0;
      push       = '0;
      for (int i = 0; i < INPUTS; i++) begin
         fifo_ne[i]    = (fifo_cnt[i] != 2'd0);
         in_ready_o[i] = rst_i && (fifo_cnt[i] != 2'd2);
         push[i]       = in_valid_i[i] && in_ready_o[i];
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < INPUTS; k++) begin
         scan_idx = GW'((int'(rr_ptr) + k) % INPUTS);
         if (!grant_vld && fifo_ne[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < INPUTS; i++) begin
         pop[i] = load && grant_vld && (grant_idx == GW'(i));
      end
   end

   // grant_o doubles as the previous winner for burst counting.
   always_comb begin
      rr_nxt    = rr_ptr;
      burst_nxt = burst_cnt;
      if (load && grant_vld) begin
         if (grant_idx == grant_o) begin
            burst_nxt = burst_cnt + 1'b1;
         end else begin
            burst_nxt = BW'(1);
            rr_nxt    = grant_idx;
         end
         if (burst_nxt == BW'(MAX_BURST)) begin
            rr_nxt    = GW'((int'(grant_idx) + 1) % INPUTS);
            burst_nxt = '0;
         end
      end
   end

   always_comb begin
      any_ne = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         any_ne = any_ne || fifo_ne[i];
      end
   end

   assign idle_o = !any_ne && !msg_valid_o;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < INPUTS; i++) begin
            fifo_cnt[i] <= 2'd0;
            fifo_wp[i]  <= 1'b0;
            fifo_rp[i]  <= 1'b0;
         end
         msg_valid_o <= 1'b0;
         msg_data_o  <= '0;
         grant_o     <= '0;
         rr_ptr      <= '0;
         burst_cnt   <= '0;
      end else begin
         for (int i = 0; i < INPUTS; i++) begin
            if (push[i]) begin
               fifo_mem[i][fifo_wp[i]] <= in_data_i[i];
               fifo_wp[i]              <= ~fifo_wp[i];
            end
            if (pop[i]) begin
               fifo_rp[i] <= ~fifo_rp[i];
            end
            if (push[i] && !pop[i]) begin
               fifo_cnt[i] <= fifo_cnt[i] + 2'd1;
            end else if (!push[i] && pop[i]) begin
               fifo_cnt[i] <= fifo_cnt[i] - 2'd1;
            end
         end
         if (load) begin
            msg_valid_o <= grant_vld;
            if (grant_vld) begin
               msg_data_o <= fifo_mem[grant_idx][fifo_rp[grant_idx]];
               grant_o    <= grant_idx;
            end
         end
         rr_ptr    <= rr_nxt;
         burst_cnt <= burst_nxt;
      end
   end

endmodule

// File: tb/tb_nx_node_egress_arbiter.sv
// Directed bench for nx_node_egress_arbiter: default 2-source/burst-4 instance plus
// a 3-source pure round-robin instance.

module tb_nx_node_egress_arbiter;
   import nx_node_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   node_message_t [1:0] in_data;
   logic [1:0]          in_valid;
   logic [1:0]          in_ready;
   node_message_t       msg_data;
   logic                msg_valid;
   logic                msg_ready;
   logic                idle;
   logic                grant;

   logic                rst3;
   node_message_t [2:0] in_data3;
   logic [2:0]          in_valid3;
   logic [2:0]          in_ready3;
   node_message_t       msg_data3;
   logic                msg_valid3;
   logic                msg_ready3;
   logic                idle3;
   logic [1:0]          grant3;

   int tx [2];
   int rx [2];
   int passed = 0;
   int failed = 0;
   int total  = 0;

   function automatic node_message_t mk(input int s, input int n);
      node_message_t m;
      m.cmd     = 4'(s + 1);
      m.addr    = 12'(n);
      m.payload = 16'(32'hB000 ^ (s << 8) ^ n);
      return m;
   endfunction

   assign in_data[0]  = mk(0, tx[0]);
   assign in_data[1]  = mk(1, tx[1]);
   assign in_data3[0] = mk(0, 0);
   assign in_data3[1] = mk(1, 0);
   assign in_data3[2] = mk(2, 0);

   nx_node_egress_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .idle_o      (idle),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .msg_data_o  (msg_data),
      .msg_valid_o (msg_valid),
      .msg_ready_i (msg_ready),
      .grant_o     (grant)
   );

   nx_node_egress_arbiter #(.INPUTS(3), .MAX_BURST(1)) dut3 (
      .clk_i       (clk),
      .rst_i       (rst3),
      .idle_o      (idle3),
      .in_data_i   (in_data3),
      .in_valid_i  (in_valid3),
      .in_ready_o  (in_ready3),
      .msg_data_o  (msg_data3),
      .msg_valid_o (msg_valid3),
      .msg_ready_i (msg_ready3),
      .grant_o     (grant3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; source sequence numbers move on only for accepted pushes.
   task automatic step();
      logic [1:0] p;
      #1;
      p = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) if (p[s]) tx[s]++;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         tx[s] = 0;
         rx[s] = 0;
      end
   endtask

   initial begin
      int g;
      tx[0] = 0; tx[1] = 0; rx[0] = 0; rx[1] = 0;
      rst        = 1'b0;
      in_valid   = 2'b11;
      msg_ready  = 1'b1;
      rst3       = 1'b0;
      in_valid3  = 3'b111;
      msg_ready3 = 1'b1;

      // Reset held with sources requesting
      for (int t = 0; t < 3; t++) begin
         step();
         chk("rst_in_ready", 32'(in_ready), 32'h0);
         chk("rst_msg_valid", 32'(msg_valid), 32'h0);
         chk("rst_idle", 32'(idle), 32'h1);
      end
      chk("rst_msg_data", msg_data, 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      rst      = 1'b1;
      in_valid = 2'b00;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'h3);
      for (int t = 0; t < 2; t++) begin
         step();
         chk("post_rst_no_emit", 32'(msg_valid), 32'h0);
         chk("post_rst_idle", 32'(idle), 32'h1);
      end

      // Single source: A0 pushed at the first edge appears after the second edge
      for (int t = 0; t < 9; t++) begin
         in_valid = (t < 6) ? 2'b01 : 2'b00;
         step();
         if (t >= 1 && t <= 6) begin
            chk("lat_valid", 32'(msg_valid), 32'h1);
            chk("lat_data", msg_data, mk(0, t - 1));
            chk("lat_grant", 32'(grant), 32'h0);
         end else begin
            chk("lat_idle_valid", 32'(msg_valid), 32'h0);
         end
      end

      // Saturated contention, burst of 4
      pulse_reset();
      in_valid = 2'b11;
      step();
      for (int t = 0; t < 12; t++) begin
         step();
         g = (t / 4) % 2;
         chk("sat_valid", 32'(msg_valid), 32'h1);
         chk("sat_grant", 32'(grant), 32'(g));
         chk("sat_data", msg_data, mk(g, rx[g]));
         rx[g]++;
      end
      in_valid = 2'b00;
      for (int t = 0; t < 10 && !idle; t++) step();
      chk("sat_drain_idle", 32'(idle), 32'h1);

      // Backpressure on source 1
      pulse_reset();
      msg_ready = 1'b0;
      in_valid  = 2'b10;
      for (int t = 1; t <= 6; t++) begin
         step();
         in_valid[1] = (tx[1] < 8);
         if (t == 1) begin
            chk("bp_ready_early", 32'(in_ready[1]), 32'h1);
            chk("bp_valid_early", 32'(msg_valid), 32'h0);
         end else begin
            chk("bp_hold_valid", 32'(msg_valid), 32'h1);
            chk("bp_hold_data", msg_data, mk(1, 0));
         end
         if (t >= 3) chk("bp_ready_low", 32'(in_ready[1]), 32'h0);
      end
      msg_ready = 1'b1;
      for (int c = 0; c < 40 && rx[1] < 8; c++) begin
         if (msg_valid) begin
            chk("bp_data", msg_data, mk(1, rx[1]));
            chk("bp_grant", 32'(grant), 32'h1);
            rx[1]++;
         end
         in_valid[1] = (tx[1] < 8);
         step();
      end
      chk("bp_count", 32'(rx[1]), 32'h8);
      in_valid = 2'b00;
      chk("bp_no_dup", 32'(msg_valid), 32'h0);
      step();
      chk("bp_idle", 32'(idle), 32'h1);

      // Reset with both FIFOs full and the output stage loaded
      msg_ready = 1'b0;
      in_valid  = 2'b11;
      for (int t = 0; t < 4; t++) step();
      chk("mid_full_ready", 32'(in_ready), 32'h0);
      chk("mid_full_valid", 32'(msg_valid), 32'h1);
      rst = 1'b0;
      step();
      chk("mid_rst_ready", 32'(in_ready), 32'h0);
      chk("mid_rst_valid", 32'(msg_valid), 32'h0);
      chk("mid_rst_data", msg_data, 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_idle", 32'(idle), 32'h1);
      rst       = 1'b1;
      in_valid  = 2'b00;
      msg_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         step();
         chk("mid_discard", 32'(msg_valid), 32'h0);
      end
      chk("mid_ready_back", 32'(in_ready), 32'h3);

      // Three sources, pure round-robin
      rst3 = 1'b1;
      step();
      for (int t = 0; t < 6; t++) begin
         step();
         chk("rr3_valid", 32'(msg_valid3), 32'h1);
         chk("rr3_grant", 32'(grant3), 32'(t % 3));
         chk("rr3_data", msg_data3, mk(t % 3, 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
